pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side counterpart to the team's free-running PWM generator and is used for loopback self-test and for reading external PWM sources such as fan tach and servo feedback. A measurement is published once per PWM period, on each rising edge of the input after the first.

---
 rtl/pwm_capture.sv | 165 ++++++++++++++++
 tb/tb_pwm_capture.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its high time
// and period in clock cycles. One measurement is published per PWM period, on
// every rising edge of the input after the first one that follows reset or
// enable.
//
// Optional feature: define PWM_CAPTURE_TIMEOUT_EN to publish a flat-line
// result (timeout=1) when the counter saturates with no edge arriving. When it
// is undefined the block waits indefinitely and timeout is tied low.
//
// Parameters:
//   R           - generator resolution; result counters are R+1 bits wide
//   SYNC_STAGES - flops in the pwm_in synchronizer (at least 2)
// Ports:
//   clk          - clock, rising edge
//   reset_n      - asynchronous active-low reset
//   enable       - capture enable; low holds the block idle
//   pwm_in       - asynchronous PWM input
//   high_count   - high cycles of the last completed period
//   period_count - cycles between the last two rising edges
//   valid        - one-cycle pulse when the results update
//   overflow     - last published measurement saturated
//   timeout      - last publication was a flat-line timeout
module pwm_capture #(
  parameter int R           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pwm_in,
  output logic [R:0] high_count,
  output logic [R:0] period_count,
  output logic       valid,
  output logic       overflow,
  output logic       timeout
);

  localparam logic [R:0] MAX = '1;
  localparam logic [R:0] ONE = {{R{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_d_p1;
  logic                   rise;
  logic                   fall;
  logic                   flat;
  logic [R:0]             cnt;
  logic [R:0]             cnt_inc;
  logic [R:0]             hi_reg;
  logic                   sat;

  function automatic logic [R:0] sat_inc(input logic [R:0] v);
    return (v == MAX) ? MAX : v + ONE;
  endfunction

  // ---- stage 0/1: input synchronizer and edge-history flop ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      s_d_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
      s_d_p1  <= s;
    end
  end

  assign s       = sync_p0[SYNC_STAGES-1];
  assign rise    = s & ~s_d_p1;
  assign fall    = ~s & s_d_p1;
  assign cnt_inc = sat_inc(cnt);

`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic timeout_r;

  // Counter already pinned at MAX and the edge that would end the phase is
  // still missing: the input is stuck.
  assign flat = (cnt == MAX) &&
                (((state == HIGH) && !fall) || ((state == LOW) && !rise));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_r <= 1'b0;
    end else if (enable) begin
      if (flat)
        timeout_r <= 1'b1;
      else if ((state == LOW) && rise)
        timeout_r <= 1'b0;
    end
  end

  assign timeout = timeout_r;
`else
  assign flat    = 1'b0;
  assign timeout = 1'b0;
`endif

  // ---- stage 2: measurement FSM and registered results ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_reg       <= '0;
      sat          <= 1'b0;
      high_count   <= '0;
      period_count <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        sat   <= 1'b0;
      end else if (flat) begin
        valid        <= 1'b1;
        overflow     <= 1'b1;
        period_count <= MAX;
        high_count   <= (state == HIGH) ? MAX : '0;
        state        <= IDLE;
        cnt          <= '0;
        sat          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state <= HIGH;
              cnt   <= ONE;
              sat   <= 1'b0;
            end
          end
          HIGH: begin
            cnt <= cnt_inc;
            if (cnt_inc == MAX)
              sat <= 1'b1;
            if (fall) begin
              hi_reg <= cnt;
              state  <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              period_count <= cnt;
              high_count   <= hi_reg;
              overflow     <= sat;
              valid        <= 1'b1;
              state        <= HIGH;
              cnt          <= ONE;
              sat          <= 1'b0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == MAX)
                sat <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: drives PWM periods of known high/low length and
// compares every publication (values, overflow, timeout, cycle of arrival)
// with expectations derived from the waveform lengths.
module tb_pwm_capture;

  localparam int unsigned R   = 8;
  localparam int unsigned SS  = 2;
  localparam int unsigned MAX = (1 << (R + 1)) - 1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pwm_in;
  logic [R:0] high_count;
  logic [R:0] period_count;
  logic       valid;
  logic       overflow;
  logic       timeout;

  typedef struct {
    int unsigned hi;
    int unsigned per;
    int unsigned ovf;
    int unsigned to;
    int unsigned cyc;
  } pub_t;

  pub_t        got_q[$];
  pub_t        exp_q[$];
  pub_t        last_exp;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned dbl = 0;
  logic        valid_prev = 1'b0;
  bit          armed = 1'b0;
  int unsigned last_h = 0;
  int unsigned last_l = 0;
  int unsigned rc_main;

  pwm_capture #(.R(R), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .valid        (valid),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every publication with the number of the edge that produced it.
  always @(negedge clk) begin
    pub_t p;
    if (valid) begin
      p.hi  = 32'(high_count);
      p.per = 32'(period_count);
      p.ovf = 32'(overflow);
      p.to  = 32'(timeout);
      p.cyc = cyc;
      got_q.push_back(p);
    end
    if (valid && valid_prev) dbl++;
    valid_prev = valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned clampv(input int unsigned v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic push(input int unsigned hi, input int unsigned per, input int unsigned ovf,
                      input int unsigned to, input int unsigned c);
    pub_t p;
    p.hi = hi; p.per = per; p.ovf = ovf; p.to = to; p.cyc = c;
    exp_q.push_back(p);
    last_exp = p;
  endtask

  // Raise pwm_in; a rise closes the previous period if one is being measured.
  task automatic begin_rise(output int unsigned rc);
    pwm_in = 1'b1;
    rc = cyc + 1;
    if (armed)
      push(clampv(last_h), clampv(last_h + last_l),
           (last_h + last_l >= MAX) ? 1 : 0, 0, rc + SS);
  endtask

  task automatic drive_period(input int unsigned h, input int unsigned l);
    int unsigned rc;
    begin_rise(rc);
    armed  = 1'b1;
    last_h = h;
    last_l = l;
    if (TO_EN && h > MAX) begin
      push(MAX, MAX, 1, 1, rc + SS + MAX);
      armed = 1'b0;
    end else if (TO_EN && h + l > MAX) begin
      push(0, MAX, 1, 1, rc + SS + MAX);
      armed = 1'b0;
    end
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic drive_with_drop(input int unsigned h, input int unsigned l);
    int unsigned rc;
    begin_rise(rc);
    armed = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l / 2) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_valid", 32'(valid), 0);
    check("drop_hold_hi", 32'(high_count), last_exp.hi);
    check("drop_hold_per", 32'(period_count), last_exp.per);
    enable = 1'b1;
    repeat (l - l / 2) @(negedge clk);
    armed = 1'b0;
  endtask

  task automatic compare(input string tag);
    repeat (4) @(negedge clk);
    last_l += 4;
    check($sformatf("%s.count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s[%0d].hi", tag, i), got_q[i].hi, exp_q[i].hi);
      check($sformatf("%s[%0d].per", tag, i), got_q[i].per, exp_q[i].per);
      check($sformatf("%s[%0d].ovf", tag, i), got_q[i].ovf, exp_q[i].ovf);
      check($sformatf("%s[%0d].to", tag, i), got_q[i].to, exp_q[i].to);
      check($sformatf("%s[%0d].cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_high_count", 32'(high_count), 0);
    check("rst_period_count", 32'(period_count), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);

    repeat (4) drive_period(64, 192);
    compare("duty64");

    repeat (3) drive_period(255, 1);
    repeat (3) drive_period(1, 255);
    compare("duty_swap");

    for (int i = 0; i < 12; i++)
      drive_period($urandom_range(1, 200), $urandom_range(1, 250));
    compare("random");

    drive_period(50, 600);
    drive_period(40, 100);
    drive_period(40, 100);
    compare("flat_low");

    drive_period(600, 20);
    drive_period(30, 60);
    drive_period(30, 60);
    compare("flat_high");

    drive_period(70, 200);
    drive_with_drop(70, 200);
    drive_period(70, 200);
    drive_period(70, 200);
    drive_period(70, 200);
    compare("enable_drop");

    drive_period(90, 110);
    begin_rise(rc_main);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_high_count", 32'(high_count), 0);
    check("midrst_period_count", 32'(period_count), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_timeout", 32'(timeout), 0);
    pwm_in = 1'b0;
    armed  = 1'b0;
    repeat (3) @(negedge clk);
    compare("pre_reset");
    reset_n = 1'b1;

    repeat (3) drive_period(80, 120);
    compare("post_reset");

    check("valid_single_cycle", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
